// File: rtl/conv8x8_pool_pkg.sv
// Shared widths and bit-index helpers for the 8x8 conv + 2x2 max-pool block.
package conv_pkg;

  localparam int PIX_W  = 2;
  localparam int WGT_W  = 2;
  localparam int IMG_N  = 8;
  localparam int K_N    = 3;
  localparam int CONV_N = 6;
  localparam int POOL_N = 3;
  localparam int ACC_W  = 8;

  localparam int IMG_W = IMG_N * IMG_N * PIX_W;
  localparam int KER_W = K_N * K_N * WGT_W;
  localparam int OUT_W = POOL_N * POOL_N * ACC_W;

  function automatic int pix_lsb(input int r, input int c);
    return IMG_N * PIX_W * r + PIX_W * c;
  endfunction

  function automatic int wgt_lsb(input int i, input int j);
    return K_N * WGT_W * i + WGT_W * j;
  endfunction

  function automatic int out_lsb(input int pr, input int pc);
    return POOL_N * ACC_W * pr + ACC_W * pc;
  endfunction

endpackage

// File: rtl/conv8x8_pool_if.sv
// Frame-parallel data bus: image and kernel toward the block, pooled map back.
interface conv8x8_pool_if;
  import conv_pkg::*;

  logic [IMG_W-1:0] in;
  logic [KER_W-1:0] filter;
  logic [OUT_W-1:0] out;

  modport master (output in, output filter, input out);
  modport slave  (input in, input filter, output out);
endinterface

// File: rtl/conv8x8_pool_mac3x3.sv
// Combinational 9-tap unsigned dot product; window and kernel share the same tap layout.
module conv_mac3x3
  import conv_pkg::*;
(
  input  logic [KER_W-1:0] window,
  input  logic [KER_W-1:0] kernel,
  output logic [ACC_W-1:0] sum
);

  logic [PIX_W+WGT_W-1:0] prod [K_N*K_N];

  for (genvar k = 0; k < K_N*K_N; k++) begin : g_tap
    assign prod[k] = {{WGT_W{1'b0}}, window[WGT_W*k +: PIX_W]}
                   * {{PIX_W{1'b0}}, kernel[WGT_W*k +: WGT_W]};
  end

  // 9 * max(9) = 81 fits in 8 bits, so the accumulation never wraps
  always_comb begin
    sum = '0;
    for (int k = 0; k < K_N*K_N; k++) begin
      sum = sum + {{(ACC_W-PIX_W-WGT_W){1'b0}}, prod[k]};
    end
  end

endmodule

// File: rtl/conv8x8_pool.sv
// 3x3 valid conv over an 8x8 2-bit frame followed by 2x2 max-pool; 2-stage pipeline.
// CONV8X8_IN_REG_EN adds an input register in front of the conv stage (latency 3).
module conv8x8_pool
  import conv_pkg::*;
(
  input logic            clk,
  input logic            rst_n,
  conv8x8_pool_if.slave  bus
);

  logic [IMG_W-1:0] img;
  logic [KER_W-1:0] flt;

`ifdef CONV8X8_IN_REG_EN
  logic [IMG_W-1:0] img_q;
  logic [KER_W-1:0] flt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      img_q <= '0;
      flt_q <= '0;
    end else begin
      img_q <= bus.in;
      flt_q <= bus.filter;
    end
  end

  assign img = img_q;
  assign flt = flt_q;
`else
  assign img = bus.in;
  assign flt = bus.filter;
`endif

  // Gather the 3x3 neighbourhood at (r,c) into the same tap order as the kernel
  function automatic logic [KER_W-1:0] window_at(input logic [IMG_W-1:0] frame,
                                                 input int r, input int c);
    logic [KER_W-1:0] w;
    w = '0;
    for (int i = 0; i < K_N; i++) begin
      for (int j = 0; j < K_N; j++) begin
        w[wgt_lsb(i, j) +: PIX_W] = frame[pix_lsb(r + i, c + j) +: PIX_W];
      end
    end
    return w;
  endfunction

  function automatic logic [ACC_W-1:0] max4(input logic [ACC_W-1:0] a, input logic [ACC_W-1:0] b,
                                            input logic [ACC_W-1:0] c, input logic [ACC_W-1:0] d);
    logic [ACC_W-1:0] m0;
    logic [ACC_W-1:0] m1;
    m0 = (a > b) ? a : b;
    m1 = (c > d) ? c : d;
    return (m0 > m1) ? m0 : m1;
  endfunction

  logic [ACC_W-1:0] conv_d [CONV_N*CONV_N];
  logic [ACC_W-1:0] conv_q [CONV_N*CONV_N];

  for (genvar r = 0; r < CONV_N; r++) begin : g_row
    for (genvar c = 0; c < CONV_N; c++) begin : g_col
      logic [KER_W-1:0] win;
      assign win = window_at(img, r, c);

      conv_mac3x3 u_mac (
        .window (win),
        .kernel (flt),
        .sum    (conv_d[r*CONV_N + c])
      );
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < CONV_N*CONV_N; k++) conv_q[k] <= '0;
    end else begin
      for (int k = 0; k < CONV_N*CONV_N; k++) conv_q[k] <= conv_d[k];
    end
  end

  logic [OUT_W-1:0] pool_d;
  logic [OUT_W-1:0] pool_q;

  always_comb begin
    pool_d = '0;
    for (int pr = 0; pr < POOL_N; pr++) begin
      for (int pc = 0; pc < POOL_N; pc++) begin
        pool_d[out_lsb(pr, pc) +: ACC_W] = max4(conv_q[(2*pr)*CONV_N + 2*pc],
                                                conv_q[(2*pr)*CONV_N + 2*pc + 1],
                                                conv_q[(2*pr+1)*CONV_N + 2*pc],
                                                conv_q[(2*pr+1)*CONV_N + 2*pc + 1]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pool_q <= '0;
    else        pool_q <= pool_d;
  end

  assign bus.out = pool_q;

endmodule

// File: tb/tb_conv8x8_pool.sv
// Directed bench for conv8x8_pool: hand-computed frames, back-to-back stream and async reset.
module tb_conv8x8_pool;
  import conv_pkg::*;

`ifdef CONV8X8_IN_REG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  conv8x8_pool_if bus ();

  conv8x8_pool dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [OUT_W-1:0] got, input logic [OUT_W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One bit per pixel, row 0 in the top byte, column 0 at the byte MSB
  function automatic logic [IMG_W-1:0] img_from_bits(input logic [63:0] m);
    logic [IMG_W-1:0] img;
    img = '0;
    for (int r = 0; r < IMG_N; r++)
      for (int c = 0; c < IMG_N; c++)
        img[pix_lsb(r, c) +: PIX_W] = {1'b0, m[63 - (8*r + c)]};
    return img;
  endfunction

  task automatic apply_and_check(input string tag, input logic [IMG_W-1:0] img,
                                 input logic [KER_W-1:0] flt, input logic [OUT_W-1:0] exp);
    @(negedge clk);
    bus.in     = img;
    bus.filter = flt;
    repeat (LAT) @(negedge clk);
    check(tag, bus.out, exp);
  endtask

  logic [IMG_W-1:0] img_center;
  logic [IMG_W-1:0] img_all3;
  logic [IMG_W-1:0] img_corner;
  logic [IMG_W-1:0] img_orient;
  logic [IMG_W-1:0] img_rand;
  logic [KER_W-1:0] flt_center;
  logic [KER_W-1:0] flt_all3;
  logic [KER_W-1:0] flt_corner;
  logic [KER_W-1:0] flt_orient;
  logic [IMG_W-1:0] s_img [3];
  logic [KER_W-1:0] s_flt [3];
  logic [OUT_W-1:0] s_exp [3];

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    bus.in     = '0;
    bus.filter = '0;

    img_center = img_from_bits({8'b11011001, 8'b00111110, 8'b10001101, 8'b00010101,
                                8'b11010010, 8'b01101101, 8'b11101101, 8'b11010110});
    flt_center = '0;
    flt_center[wgt_lsb(1, 1) +: WGT_W] = 2'd1;

    img_all3 = '1;
    flt_all3 = '1;

    img_corner = '0;
    img_corner[pix_lsb(7, 7) +: PIX_W] = 2'd3;
    flt_corner = '0;
    flt_corner[wgt_lsb(2, 2) +: WGT_W] = 2'd2;

    // F(0,1)=1 with P(2,3)=2 lands on C(2,2), i.e. pooled element (1,1)
    img_orient = '0;
    img_orient[pix_lsb(2, 3) +: PIX_W] = 2'd2;
    flt_orient = '0;
    flt_orient[wgt_lsb(0, 1) +: WGT_W] = 2'd1;

    img_rand = {$urandom, $urandom, $urandom, $urandom};

    repeat (3) @(negedge clk);
    check("reset_out", bus.out, 72'h0);
    rst_n = 1'b1;

    apply_and_check("center_kernel", img_center, flt_center, 72'h01_0101_0101_0101_0101);
    apply_and_check("all_threes",    img_all3,   flt_all3,   72'h515151515151515151);
    apply_and_check("zero_filter",   img_rand,   18'h0,      72'h0);
    apply_and_check("corner_pixel",  img_corner, flt_corner, 72'h06_0000_0000_0000_0000);
    apply_and_check("all_ones",      img_from_bits(64'hFFFF_FFFF_FFFF_FFFF), 18'h15555,
                    72'h090909090909090909);
    apply_and_check("orientation",   img_orient, flt_orient, 72'h00_0000_0002_0000_0000);

    // Back-to-back A, B, A: each result LAT negedges after it was driven
    s_img[0] = img_all3;   s_flt[0] = flt_all3;   s_exp[0] = 72'h515151515151515151;
    s_img[1] = img_corner; s_flt[1] = flt_corner; s_exp[1] = 72'h06_0000_0000_0000_0000;
    s_img[2] = img_all3;   s_flt[2] = flt_all3;   s_exp[2] = 72'h515151515151515151;
    for (int k = 0; k < 3 + LAT; k++) begin
      @(negedge clk);
      if (k >= LAT) check($sformatf("stream_%0d", k - LAT), bus.out, s_exp[k - LAT]);
      if (k < 3) begin
        bus.in     = s_img[k];
        bus.filter = s_flt[k];
      end
    end

    // Pipeline full of all-threes; reset between edges must clear out at once
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", bus.out, 72'h0);
    @(negedge clk);
    bus.in     = img_corner;
    bus.filter = flt_corner;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < LAT - 1; k++) begin
      @(negedge clk);
      check($sformatf("post_reset_zero_%0d", k), bus.out, 72'h0);
    end
    @(negedge clk);
    check("post_reset_first", bus.out, 72'h06_0000_0000_0000_0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
